// File: rtl/mvm_input_dispatcher.sv
// Host-side input injector for the MVM mesh NoC: buffers {last, vector} entries in a
// first-word fall-through FIFO and streams each one as a single-flit AXI-Stream packet.
module mvm_input_dispatcher #(
    parameter int DATAW      = 512,
    parameter int IDW        = 2,
    parameter int DESTW      = 4,
    parameter int DESTNODE   = 0,
    parameter int TID_VALUE  = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_fifo_wen,
    input  logic [DATAW-1:0] data_fifo_wdata,
    input  logic             data_last,
    output logic             data_fifo_rdy,
    output logic             axis_tx_tvalid,
    input  logic             axis_tx_tready,
    output logic [DATAW-1:0] axis_tx_tdata,
    output logic             axis_tx_tlast,
    output logic [IDW-1:0]   axis_tx_tid,
    output logic [DESTW-1:0] axis_tx_tdest
);

    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(FIFO_DEPTH);

    logic [DATAW:0]  mem_q [FIFO_DEPTH];
    logic [PTRW-1:0] rptr_q, rptr_d;
    logic [PTRW-1:0] wptr_q, wptr_d;
    logic [PTRW:0]   count_q, count_d;
    logic            push, pop;

    // Ready looks only at registered occupancy, so a simultaneous pop never frees a slot early.
    assign data_fifo_rdy  = (count_q != FULL_COUNT);
    assign axis_tx_tvalid = (count_q != '0);
    assign push           = data_fifo_wen && data_fifo_rdy;
    assign pop            = axis_tx_tvalid && axis_tx_tready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + PTRW'(1);
        if (pop)  rptr_d = rptr_q + PTRW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTRW+1)'(1);
            2'b01:   count_d = count_q - (PTRW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates its visibility, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (push && rst_n) mem_q[wptr_q] <= {data_last, data_fifo_wdata};
    end

    assign axis_tx_tdata = mem_q[rptr_q][DATAW-1:0];
    assign axis_tx_tlast = mem_q[rptr_q][DATAW];
    assign axis_tx_tid   = IDW'(TID_VALUE);
    assign axis_tx_tdest = DESTW'(DESTNODE);

endmodule

// File: tb/tb_mvm_input_dispatcher.sv
// Self-checking bench for mvm_input_dispatcher: directed vector tables, multi-cycle
// corner sequences and randomized traffic against a queue-based reference model.
module tb_mvm_input_dispatcher;

    localparam int DATAW      = 512;
    localparam int IDW        = 2;
    localparam int DESTW      = 4;
    localparam int DESTNODE   = 3;
    localparam int TID_VALUE  = 0;
    localparam int FIFO_DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             data_fifo_wen = 1'b0;
    logic [DATAW-1:0] data_fifo_wdata = '0;
    logic             data_last = 1'b0;
    logic             data_fifo_rdy;
    logic             axis_tx_tvalid;
    logic             axis_tx_tready = 1'b0;
    logic [DATAW-1:0] axis_tx_tdata;
    logic             axis_tx_tlast;
    logic [IDW-1:0]   axis_tx_tid;
    logic [DESTW-1:0] axis_tx_tdest;

    mvm_input_dispatcher #(
        .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .DESTNODE(DESTNODE),
        .TID_VALUE(TID_VALUE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_fifo_wen(data_fifo_wen), .data_fifo_wdata(data_fifo_wdata),
        .data_last(data_last), .data_fifo_rdy(data_fifo_rdy),
        .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
        .axis_tx_tdata(axis_tx_tdata), .axis_tx_tlast(axis_tx_tlast),
        .axis_tx_tid(axis_tx_tid), .axis_tx_tdest(axis_tx_tdest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             wen;
        logic             last;
        logic [DATAW-1:0] wdata;
        logic             tready;
        logic             exp_valid;
        logic             exp_rdy;
        logic [DATAW-1:0] exp_data;
        logic             exp_last;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue of {last, data} entries.
    logic [DATAW:0] model_q[$];

    task automatic check(input string name, input logic [DATAW:0] act, input logic [DATAW:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] rand_vec();
        logic [DATAW-1:0] v;
        for (int i = 0; i < DATAW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: drive inputs, advance model and DUT, compare everything the model predicts.
    task automatic drive_cycle(input logic wen, input logic last, input logic [DATAW-1:0] wdata,
                               input logic tready, output logic accepted, output logic fired);
        logic m_rdy, m_valid;
        data_fifo_wen   = wen;
        data_last       = last;
        data_fifo_wdata = wdata;
        axis_tx_tready  = tready;
        m_rdy    = (model_q.size() < FIFO_DEPTH);
        m_valid  = (model_q.size() != 0);
        accepted = wen && m_rdy;
        fired    = axis_tx_tvalid && tready;
        @(posedge clk);
        if (m_valid && tready) void'(model_q.pop_front());
        if (accepted) model_q.push_back({last, wdata});
        #1;
        check("model_tvalid", axis_tx_tvalid, model_q.size() != 0);
        check("model_rdy", data_fifo_rdy, model_q.size() < FIFO_DEPTH);
        check("tid", axis_tx_tid, IDW'(TID_VALUE));
        check("tdest", axis_tx_tdest, DESTW'(DESTNODE));
        if (model_q.size() != 0) check("model_head", {axis_tx_tlast, axis_tx_tdata}, model_q[0]);
    endtask

    task automatic do_reset(input logic wen_during);
        rst_n          = 1'b0;
        data_fifo_wen  = wen_during;
        data_fifo_wdata = DATAW'(32'hdead);
        axis_tx_tready = 1'b0;
        @(posedge clk);
        model_q.delete();
        #1;
        rst_n         = 1'b1;
        data_fifo_wen = 1'b0;
        check("rst_tvalid", axis_tx_tvalid, 1'b0);
        check("rst_rdy", data_fifo_rdy, 1'b1);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic acc, fire;
        drive_cycle(v.wen, v.last, v.wdata, v.tready, acc, fire);
        check($sformatf("tbl%0d_tvalid", idx), axis_tx_tvalid, v.exp_valid);
        check($sformatf("tbl%0d_rdy", idx), data_fifo_rdy, v.exp_rdy);
        if (v.exp_valid) begin
            check($sformatf("tbl%0d_tdata", idx), axis_tx_tdata, v.exp_data);
            check($sformatf("tbl%0d_tlast", idx), axis_tx_tlast, v.exp_last);
        end
    endtask

    initial begin
        vec_t tbl[8];
        logic acc, fire;
        int   sent, popped, cyc;
        logic [DATAW-1:0] va, vb, vc;

        va = DATAW'(32'h0a0a);
        vb = DATAW'(32'h0b0b);
        vc = DATAW'(32'h0c0c);
        // Single write with tready=1: visible one cycle after the push, gone the next.
        tbl[0] = '{1'b1, 1'b1, DATAW'(16'h0103), 1'b1, 1'b1, 1'b1, DATAW'(16'h0103), 1'b1};
        tbl[1] = '{1'b0, 1'b0, '0,               1'b1, 1'b0, 1'b1, '0,               1'b0};
        // Last-flag pass-through: A(0), B(1), C(0) buffered, then drained.
        tbl[2] = '{1'b1, 1'b0, va, 1'b0, 1'b1, 1'b1, va, 1'b0};
        tbl[3] = '{1'b1, 1'b1, vb, 1'b0, 1'b1, 1'b1, va, 1'b0};
        tbl[4] = '{1'b1, 1'b0, vc, 1'b0, 1'b1, 1'b1, va, 1'b0};
        tbl[5] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, vb, 1'b1};
        tbl[6] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, vc, 1'b0};
        tbl[7] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, '0, 1'b0};

        @(posedge clk);
        #1;
        do_reset(1'b1);
        for (int i = 0; i < 2; i++) apply_vec(tbl[i], i);

        // Backpressure fill, ignored 17th write, then in-order drain.
        for (int i = 1; i <= FIFO_DEPTH; i++)
            drive_cycle(1'b1, 1'b0, DATAW'(i), 1'b0, acc, fire);
        check("fill_rdy_low", data_fifo_rdy, 1'b0);
        check("fill_head", axis_tx_tdata, DATAW'(1));
        drive_cycle(1'b1, 1'b0, DATAW'(17), 1'b0, acc, fire);
        check("fill_17_head", axis_tx_tdata, DATAW'(1));
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            check($sformatf("drain_%0d", i), axis_tx_tdata, DATAW'(i));
            drive_cycle(1'b0, 1'b0, '0, 1'b1, acc, fire);
            if (i == 1) check("drain_rdy_back", data_fifo_rdy, 1'b1);
        end
        check("drain_empty", axis_tx_tvalid, 1'b0);

        // Concurrent push/pop: four back-to-back beats, tlast only on the fourth.
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, i == 3, DATAW'(32'h100 + i), 1'b1, acc, fire);
            check($sformatf("stream_data_%0d", i), axis_tx_tdata, DATAW'(32'h100 + i));
            check($sformatf("stream_last_%0d", i), axis_tx_tlast, i == 3);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1, acc, fire);
        check("stream_end", axis_tx_tvalid, 1'b0);

        // Randomized traffic with wrap-around and random backpressure.
        sent = 0; popped = 0; cyc = 0;
        while ((sent < 40 || model_q.size() != 0) && cyc < 2000) begin
            drive_cycle(sent < 40 && $urandom_range(0, 3) != 0, 1'($urandom), rand_vec(),
                        1'($urandom), acc, fire);
            if (acc) sent++;
            if (fire) popped++;
            cyc++;
        end
        if (cyc >= 2000) begin
            fails++;
            $display("FAIL wrap_timeout: got %0d cycles expected fewer than 2000", cyc);
        end
        check("wrap_popped", popped, 40);

        // Last-flag pass-through table on an empty FIFO.
        for (int i = 2; i < 8; i++) apply_vec(tbl[i], i);

        // Reset mid-operation discards the buffered entries.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, DATAW'(32'h50 + i), 1'b0, acc, fire);
        do_reset(1'b1);
        drive_cycle(1'b1, 1'b0, DATAW'(9), 1'b0, acc, fire);
        check("post_rst_first", axis_tx_tdata, DATAW'(9));
        drive_cycle(1'b0, 1'b0, '0, 1'b1, acc, fire);
        check("post_rst_empty", axis_tx_tvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mvm_input_dispatcher.md
Name: mvm_input_dispatcher

Overview:
- Host-side input injector for the MVM mesh NoC.
- Accepts input vectors from the testbench or host through a simple FIFO write port.
- Buffers each vector with its end-of-sequence marker and streams it as AXI-Stream packets into one NoC router input port.
- All packets target the fixed first-layer MVM node given by DESTNODE.

Parameters:
- DATAW, 512: width of one input vector (64 lanes x 8 bit).
- IDW, 2: width of axis_tx_tid.
- DESTW, 4: width of axis_tx_tdest.
- DESTNODE, 0: mesh node ID driven on tdest for every beat.
- TID_VALUE, 0: constant driven on axis_tx_tid.
- FIFO_DEPTH, 16: input buffer depth. Must be a power of two and at least 2.

Ports:
- clk, input, 1: user clock. All logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- data_fifo_wen, input, 1: write strobe.
- data_fifo_wdata, input, DATAW: vector to enqueue.
- data_last, input, 1: marks the final vector of a sequence. Sampled together with wen.
- data_fifo_rdy, output, 1: FIFO can accept a write this cycle.
- axis_tx_tvalid, output, 1: AXI-S valid.
- axis_tx_tready, input, 1: AXI-S ready from the NoC.
- axis_tx_tdata, output, DATAW: vector. Integration zero-extends it into the wider NoC tdata, whose upper tuser bits are 0.
- axis_tx_tlast, output, 1: stored data_last of the head entry.
- axis_tx_tid, output, IDW: equals TID_VALUE.
- axis_tx_tdest, output, DESTW: equals DESTNODE[DESTW-1:0].

Behaviour:
- Storage: circular FIFO of FIFO_DEPTH entries. Each entry is {last, data}, DATAW+1 bits wide.
- Pointers: read and write pointers of log2(FIFO_DEPTH) bits wrap modulo the depth. An occupancy counter of log2(FIFO_DEPTH)+1 bits tracks fill level.
- data_fifo_rdy = (count != FIFO_DEPTH). It is combinational from registered state and does not depend on wen.
- Push: on a rising edge with data_fifo_wen && data_fifo_rdy, the entry is stored and wptr increments.
- A wen asserted while rdy=0 is ignored. No data is stored and there is no error flag.
- TX side is first-word fall-through:
  - axis_tx_tvalid = (count != 0).
  - tdata and tlast come from the entry at rptr.
- Latency: a word pushed at edge N is visible with tvalid=1 in the cycle after edge N. Push-to-valid latency is one cycle.
- Pop: on a rising edge with tvalid && tready, rptr increments.
- AXI-S rule: while tvalid=1 and tready=0, tdata, tlast, tid and tdest hold stable. tvalid never deasserts without a handshake.
- Simultaneous push and pop in the same edge leaves count unchanged. Both pointers advance.
- Push when count == FIFO_DEPTH-1 with no pop: count becomes FIFO_DEPTH and rdy drops for the next cycle.
- Pop on an empty FIFO cannot occur, because tvalid=0.
- Every beat is a single-flit packet carrying its own tlast. There is no multi-beat framing state.
- tid and tdest are constants and are driven even while tvalid=0.
- Reset (rst_n=0 at a rising edge):
  - rptr, wptr and count are cleared.
  - Outputs become tvalid=0 and rdy=1 (after reset is applied). tdata and tlast are don't-care.
  - Reset mid-stream discards all buffered entries. A wen on the reset edge is ignored.
- The memory array needs no reset and may map to RAM. The head read is combinational (distributed RAM) or registered with look-ahead, provided the one-cycle push-to-valid latency is kept.

Test Plan:
- Reset then single write: wdata=0x...0103, last=1, tready=1. Expect tvalid=1 one cycle later, with tdata=0x...0103, tlast=1, tdest=DESTNODE (e.g. 3), tid=0. tvalid returns to 0 the next cycle.
- Backpressure fill: tready=0, write FIFO_DEPTH vectors 1..16 on consecutive cycles.
  - rdy=0 after the 16th write.
  - A 17th wen (value 17) is ignored.
  - tdata stays 1 throughout.
  - Then tready=1: outputs 1..16 in order on 16 consecutive cycles, and rdy=1 after the first pop.
- Concurrent push/pop: tready=1 with a continuous write stream of 4 vectors, the last one with last=1. Expect 4 back-to-back beats, one cycle delayed, with tlast set only on beat 4. Count never exceeds 1.
- Wrap-around: 40 vectors with random tready (50%). Expect an in-order, lossless output sequence in which every beat is held stable while tready=0.
- Reset mid-operation: 5 entries buffered, assert rst_n=0 for one cycle. Expect tvalid=0 and rdy=1 after reset. A new write of 0x9 emerges as the first beat.
- Last-flag pass-through: write A (last=0), B (last=1), C (last=0). Expect tlast values 0, 1, 0 on the respective beats.
